// File: rtl/seq_step_ctrl.sv
// -----------------------------------------------------------------------------
// seq_step_ctrl
// Step sequencer pattern-memory controller. A free-running step timer advances
// the step pointer. The single port of a synchronous step RAM (1-cycle
// registered read) is shared between record writes and playback reads. A
// pending write always goes first. The LED pattern output is updated from
// whichever access last touched the current step.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   run         1 = timer advances; 0 = timer/step frozen (writes still serviced)
//   set_req     single-cycle pulse: record ptn into the current step
//   ptn         pattern to record
//   mem_addr    RAM address (read or write)
//   mem_w_en    RAM write enable
//   mem_w_data  RAM write data
//   mem_r_en    RAM read enable
//   mem_r_data  RAM read data, valid the cycle after mem_r_en is sampled
//   step        current step index
//   led         displayed pattern
// -----------------------------------------------------------------------------
module seq_step_ctrl #(
  parameter int unsigned STEP_COUNTS = 12000000,
  parameter int unsigned NUM_STEPS   = 8,
  parameter int unsigned DATA_W      = 2,
  localparam int unsigned ADDR_W     = $clog2(NUM_STEPS),
  localparam int unsigned CNT_W      = $clog2(STEP_COUNTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              set_req,
  input  logic [DATA_W-1:0] ptn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_w_en,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic [ADDR_W-1:0] step,
  output logic [DATA_W-1:0] led
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WR     = 2'd1;
  localparam logic [1:0] ST_RD     = 2'd2;
  localparam logic [1:0] ST_RDWAIT = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_step;
  logic [ADDR_W-1:0] r_rd_step;
  logic [DATA_W-1:0] r_led;
  logic              r_wr_pend;
  logic              r_rd_pend;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_tick;
  logic [ADDR_W-1:0] w_step_inc;

  // Step boundary: last count of the current step while running
  assign w_tick     = run && (r_cnt == CNT_W'(STEP_COUNTS - 1));
  assign w_step_inc = (r_step == ADDR_W'(NUM_STEPS - 1)) ? '0 : r_step + ADDR_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and Moore memory-port decode
  always_comb begin
    w_state_nxt = r_state;
    mem_addr    = '0;
    mem_w_en    = 1'b0;
    mem_w_data  = '0;
    mem_r_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_wr_pend) begin
          w_state_nxt = ST_WR;
        end else if (r_rd_pend) begin
          w_state_nxt = ST_RD;
        end
      end
      ST_WR: begin
        mem_w_en    = 1'b1;
        mem_addr    = r_wr_addr;
        mem_w_data  = r_wr_data;
        w_state_nxt = ST_IDLE;
      end
      ST_RD: begin
        mem_r_en    = 1'b1;
        mem_addr    = r_step;
        w_state_nxt = ST_RDWAIT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Timer, step pointer, request latches and LED register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_step    <= '0;
      r_rd_step <= '0;
      r_led     <= '0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b1;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (run) begin
        if (w_tick) begin
          r_cnt  <= '0;
          r_step <= w_step_inc;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      // A new request overrides both the latch contents and the clear on service
      if (set_req) begin
        r_wr_pend <= 1'b1;
        r_wr_addr <= r_step;
        r_wr_data <= ptn;
      end else if (r_state == ST_WR) begin
        r_wr_pend <= 1'b0;
      end

      if (r_state == ST_WR && r_wr_addr == r_step) begin
        r_led <= r_wr_data;
      end

      // Remember which step the read targeted
      if (r_state == ST_RD) begin
        r_rd_step <= r_step;
      end

      if (r_state == ST_RDWAIT) begin
        r_led <= mem_r_data;
      end

      // Keep the read request alive if the step moved while the read was in flight
      if (w_tick) begin
        r_rd_pend <= 1'b1;
      end else if (r_state == ST_RDWAIT && r_rd_step == r_step) begin
        r_rd_pend <= 1'b0;
      end
    end
  end

  assign step = r_step;
  assign led  = r_led;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_step_ctrl
// Directed bench for seq_step_ctrl with STEP_COUNTS=10, NUM_STEPS=8, DATA_W=2.
// A behavioural synchronous RAM is reloaded with mem[k] = k[1:0] whenever rst
// is high. Edge numbers in comments count rising edges after rst release.
// -----------------------------------------------------------------------------
module tb_seq_step_ctrl;

  localparam int unsigned STEP_COUNTS = 10;
  localparam int unsigned NUM_STEPS   = 8;
  localparam int unsigned DATA_W      = 2;
  localparam int unsigned ADDR_W      = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              set_req;
  logic [DATA_W-1:0] ptn;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_w_data;
  logic              mem_r_en;
  logic [DATA_W-1:0] mem_r_data;
  logic [ADDR_W-1:0] step;
  logic [DATA_W-1:0] led;

  logic [DATA_W-1:0] mem [NUM_STEPS];
  int                w_cnt;
  int                checks;
  int                failures;

  seq_step_ctrl #(
    .STEP_COUNTS(STEP_COUNTS),
    .NUM_STEPS  (NUM_STEPS),
    .DATA_W     (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .set_req   (set_req),
    .ptn       (ptn),
    .mem_addr  (mem_addr),
    .mem_w_en  (mem_w_en),
    .mem_w_data(mem_w_data),
    .mem_r_en  (mem_r_en),
    .mem_r_data(mem_r_data),
    .step      (step),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Synchronous single-port step RAM with registered read
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(NUM_STEPS); k++) mem[k] <= DATA_W'(k);
      mem_r_data <= '0;
    end else begin
      if (mem_w_en) mem[mem_addr] <= mem_w_data;
      if (mem_r_en) mem_r_data <= mem[mem_addr];
    end
  end

  // Count write cycles seen by the RAM
  always @(posedge clk) begin
    if (mem_w_en === 1'b1) w_cnt = w_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    w_cnt    = 0;
    rst      = 1'b1;
    run      = 1'b1;
    set_req  = 1'b0;
    ptn      = '0;

    // Reset state
    adv(2);
    check("rst_mem_r_en", 32'(mem_r_en), 32'd0);
    check("rst_mem_w_en", 32'(mem_w_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_w_data", 32'(mem_w_data), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    rst = 1'b0;

    // Initial fetch of step 0, first tick
    adv(1);   // E1
    check("t1_rd_en", 32'(mem_r_en), 32'd1);
    check("t1_rd_addr", 32'(mem_addr), 32'd0);
    adv(1);   // E2
    check("t1_rd_en_off", 32'(mem_r_en), 32'd0);
    adv(1);   // E3
    check("t1_led0", 32'(led), 32'd0);
    adv(6);   // E9
    check("t1_step_pre", 32'(step), 32'd0);
    adv(1);   // E10
    check("t1_step1", 32'(step), 32'd1);
    adv(2);   // E12
    check("t1_led_early", 32'(led), 32'd0);
    adv(1);   // E13
    check("t1_led1", 32'(led), 32'd1);

    // Playback sweep through the wrap
    for (int s = 2; s <= 8; s++) begin
      adv(10);  // E(10s+3)
      check($sformatf("t2_step_%0d", s), 32'(step), 32'(s % 8));
      check($sformatf("t2_led_%0d", s), 32'(led), 32'((s % 8) % 4));
    end
    check("t2_no_write", 32'(w_cnt), 32'd0);

    // Record 2'b10 into step 3
    adv(31);  // E114, step 3
    set_req = 1'b1;
    ptn     = 2'b10;
    adv(1);   // E115
    set_req = 1'b0;
    check("t3_wr_not_yet", 32'(mem_w_en), 32'd0);
    adv(1);   // E116
    check("t3_w_en", 32'(mem_w_en), 32'd1);
    check("t3_w_addr", 32'(mem_addr), 32'd3);
    check("t3_w_data", 32'(mem_w_data), 32'd2);
    check("t3_led_old", 32'(led), 32'd3);
    adv(1);   // E117
    check("t3_led_new", 32'(led), 32'd2);
    check("t3_w_en_off", 32'(mem_w_en), 32'd0);
    adv(76);  // E193, step 3 on the next pass
    check("t3_pass_step", 32'(step), 32'd3);
    check("t3_pass_led", 32'(led), 32'd2);
    check("t3_mem3", 32'(mem[3]), 32'd2);
    check("t3_one_write", 32'(w_cnt), 32'd1);

    // Record on the tick edge leaving step 4
    adv(16);  // E209
    check("t4_step4", 32'(step), 32'd4);
    check("t4_led4", 32'(led), 32'd0);
    set_req = 1'b1;
    ptn     = 2'b11;
    adv(1);   // E210 tick
    set_req = 1'b0;
    check("t4_step5", 32'(step), 32'd5);
    adv(1);   // E211
    check("t4_w_en", 32'(mem_w_en), 32'd1);
    check("t4_w_addr", 32'(mem_addr), 32'd4);
    check("t4_w_data", 32'(mem_w_data), 32'd3);
    check("t4_r_en_held", 32'(mem_r_en), 32'd0);
    adv(1);   // E212
    check("t4_led_keep", 32'(led), 32'd0);
    adv(1);   // E213
    check("t4_r_en", 32'(mem_r_en), 32'd1);
    check("t4_r_addr", 32'(mem_addr), 32'd5);
    adv(1);   // E214
    check("t4_led_wait", 32'(led), 32'd0);
    adv(1);   // E215
    check("t4_led5", 32'(led), 32'd1);

    // Freeze on step 6 with cnt=4, record while frozen
    adv(8);   // E223
    check("t5_step6", 32'(step), 32'd6);
    check("t5_led6", 32'(led), 32'd2);
    adv(1);   // E224
    run = 1'b0;
    adv(5);   // E229
    set_req = 1'b1;
    ptn     = 2'b01;
    adv(1);   // E230
    set_req = 1'b0;
    adv(1);   // E231
    check("t5_w_en", 32'(mem_w_en), 32'd1);
    check("t5_w_addr", 32'(mem_addr), 32'd6);
    check("t5_w_data", 32'(mem_w_data), 32'd1);
    adv(1);   // E232
    check("t5_led_new", 32'(led), 32'd1);
    adv(42);  // E274, 50 frozen edges done
    check("t5_frozen_step", 32'(step), 32'd6);
    check("t5_writes", 32'(w_cnt), 32'd3);
    run = 1'b1;
    adv(5);   // E279, cnt back at 9
    check("t5_resume_pre", 32'(step), 32'd6);
    adv(1);   // E280
    check("t5_resume_tick", 32'(step), 32'd7);
    adv(1);   // E281, RD of step 7
    check("t6_in_rd", 32'(mem_r_en), 32'd1);
    check("t6_rd_addr", 32'(mem_addr), 32'd7);

    // Asynchronous reset while in RD
    rst = 1'b1;
    #1;
    check("t6_r_en_async", 32'(mem_r_en), 32'd0);
    check("t6_addr_async", 32'(mem_addr), 32'd0);
    check("t6_w_en_async", 32'(mem_w_en), 32'd0);
    check("t6_step_async", 32'(step), 32'd0);
    check("t6_led_async", 32'(led), 32'd0);
    adv(2);
    rst = 1'b0;
    adv(1);   // E'1
    check("t6_refetch_en", 32'(mem_r_en), 32'd1);
    check("t6_refetch_addr", 32'(mem_addr), 32'd0);
    check("t6_no_w_en", 32'(mem_w_en), 32'd0);
    adv(2);   // E'3
    check("t6_led0", 32'(led), 32'd0);
    adv(7);   // E'10
    check("t6_step1", 32'(step), 32'd1);
    adv(3);   // E'13
    check("t6_led1", 32'(led), 32'd1);
    check("t6_no_write", 32'(w_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
